// File: rtl/fmc_pkg.sv
// Shared definitions for the FMC initiator and responder pair.
package fmc_pkg;

    // Initiator bus-cycle sequencer states
    typedef enum logic [2:0] {
        FMC_IDLE    = 3'd0,
        FMC_ADDR    = 3'd1,
        FMC_LAT     = 3'd2,
        FMC_DATA    = 3'd3,
        FMC_RECOVER = 3'd4
    } fmc_init_state_t;

    // Idle bus cycles between the address cycle and the first data cycle.
    // The responder is built with the same number of wait states.
    localparam int FmcDefaultLatency = 2;

endpackage : fmc_pkg

// File: rtl/fmc_data_bus.sv
// Tristate driver for the multiplexed address/data bus.
// When tristate_out is high the bus is released; out always reflects the pins.
module fmc_data_bus #(
    parameter int Width = 16
) (
    input  logic [Width-1:0] in,
    output logic [Width-1:0] out,
    input  logic             tristate_out,
    inout  wire  [Width-1:0] data_io
);

    // Drive the pins only when the owner asks for it
    assign data_io = tristate_out ? {Width{1'bz}} : in;

    // Whatever is on the pins, driven by us or by the responder
    assign out = data_io;

endmodule : fmc_data_bus

// File: rtl/fmc_initiator.sv
// Bus master for the multiplexed FMC/PSRAM-style interface.
// One accepted command becomes: address cycle, fixed latency gap, then a
// read or write data phase of cmd_len_i + 1 beats, followed by one recovery
// cycle with chip select high.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. cmd_ready_o is high only in IDLE; wdata_ready_o is high
// only in the DATA phase of a write. The read stream has no ready: the
// consumer must accept rdata_o whenever rdata_valid_o is high.
module fmc_initiator
    import fmc_pkg::*;
#(
    parameter int AddrWidth     = 16,
    parameter int DataWidth     = 16,
    parameter int LenWidth      = 8,
    parameter int LatencyCycles = FmcDefaultLatency
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    // command channel
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_write_i,
    input  logic [AddrWidth-1:0] cmd_addr_i,
    input  logic [LenWidth-1:0]  cmd_len_i,
    // write data stream
    input  logic                 wdata_valid_i,
    output logic                 wdata_ready_o,
    input  logic [DataWidth-1:0] wdata_i,
    // read data stream
    output logic                 rdata_valid_o,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 rdata_last_o,
    // bus pins
    inout  wire  [DataWidth-1:0] data_io,
    output logic                 cs_no,
    output logic                 oe_no,
    output logic                 we_no,
    output logic                 adv_no,
    // debug view of the sequencer
    output fmc_init_state_t      dbg_state_o
);

    localparam int              LatW    = (LatencyCycles > 1) ? $clog2(LatencyCycles) : 1;
    localparam logic [LatW-1:0] LatLast = LatW'(LatencyCycles - 1);

    fmc_init_state_t       state_q;
    fmc_init_state_t       state_d;

    logic                  write_q;
    logic [AddrWidth-1:0]  addr_q;
    logic [LenWidth-1:0]   len_q;
    logic [LenWidth-1:0]   beat_q;
    logic [LatW-1:0]       lat_q;

    logic                  beat;
    logic                  last_beat;
    logic                  read_beat;

    logic [DataWidth-1:0]  bus_out;
    logic [DataWidth-1:0]  bus_in;
    logic                  bus_release;

    logic                  rdata_valid_q;
    logic                  rdata_last_q;
    logic [DataWidth-1:0]  rdata_q;

    // A write beat needs valid data; a read beat happens every DATA cycle
    assign beat      = (state_q == FMC_DATA) && (!write_q || wdata_valid_i);
    assign last_beat = beat && (beat_q == len_q);
    assign read_beat = beat && !write_q;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FMC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FMC_IDLE:    if (cmd_valid_i) state_d = FMC_ADDR;
            FMC_ADDR:    state_d = FMC_LAT;
            FMC_LAT:     if (lat_q == LatLast) state_d = FMC_DATA;
            FMC_DATA:    if (last_beat) state_d = FMC_RECOVER;
            FMC_RECOVER: state_d = FMC_IDLE;
            default:     state_d = FMC_IDLE;
        endcase
    end

    // Strobe, handshake and bus-drive decode from registered state
    always_comb begin
        cmd_ready_o   = 1'b0;
        wdata_ready_o = 1'b0;
        cs_no         = 1'b1;
        oe_no         = 1'b1;
        we_no         = 1'b1;
        adv_no        = 1'b1;
        bus_release   = 1'b1;
        bus_out       = wdata_i;
        unique case (state_q)
            FMC_IDLE: begin
                cmd_ready_o = 1'b1;
            end
            FMC_ADDR: begin
                cs_no       = 1'b0;
                adv_no      = 1'b0;
                bus_release = 1'b0;
                bus_out     = DataWidth'(addr_q);
            end
            FMC_LAT: begin
                cs_no = 1'b0;
            end
            FMC_DATA: begin
                cs_no = 1'b0;
                if (write_q) begin
                    // a stalled cycle keeps the responder selected but idle
                    wdata_ready_o = 1'b1;
                    we_no         = !wdata_valid_i;
                    bus_release   = !wdata_valid_i;
                end else begin
                    oe_no = 1'b0;
                end
            end
            FMC_RECOVER: begin
                cs_no = 1'b1;
            end
            default: begin
                cs_no = 1'b1;
            end
        endcase
    end

    // Command latch plus latency and beat counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            lat_q   <= '0;
        end else begin
            if (state_q == FMC_IDLE && cmd_valid_i) begin
                write_q <= cmd_write_i;
                addr_q  <= cmd_addr_i;
                len_q   <= cmd_len_i;
                beat_q  <= '0;
                lat_q   <= '0;
            end
            if (state_q == FMC_LAT) begin
                lat_q <= lat_q + 1'b1;
            end
            if (beat) begin
                beat_q <= beat_q + 1'b1;
            end
        end
    end

    // Read capture: the word on the pins at the closing edge of a read beat
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_valid_q <= 1'b0;
            rdata_last_q  <= 1'b0;
            rdata_q       <= '0;
        end else begin
            rdata_valid_q <= read_beat;
            rdata_last_q  <= read_beat && last_beat;
            if (read_beat) begin
                rdata_q <= bus_in;
            end
        end
    end

    assign rdata_valid_o = rdata_valid_q;
    assign rdata_last_o  = rdata_last_q;
    assign rdata_o       = rdata_q;
    assign dbg_state_o   = state_q;

    fmc_data_bus #(
        .Width(DataWidth)
    ) u_data_bus (
        .in           (bus_out),
        .out          (bus_in),
        .tristate_out (bus_release),
        .data_io      (data_io)
    );

endmodule : fmc_initiator

// File: tb/tb_fmc_initiator.sv
// Bench for fmc_initiator with a small behavioural responder on the bus.
// Each driven cycle pushes the outputs the initiator must show in that cycle;
// a compare process checks them on the falling edge.
module tb_fmc_initiator;
    import fmc_pkg::*;

    localparam int L = 2;

    typedef struct packed {
        logic        cs;
        logic        adv;
        logic        oe;
        logic        we;
        logic        crdy;
        logic        wrdy;
        logic        rval;
        logic        rlast;
        logic        chk_rd;
        logic        drv;
        logic [15:0] rdata;
        logic [15:0] bus;
    } exp_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    // DUT signals
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic        wdata_valid = 1'b0;
    logic        wdata_ready;
    logic [15:0] wdata = '0;
    logic        rdata_valid;
    logic [15:0] rdata;
    logic        rdata_last;
    wire  [15:0] bus;
    logic        cs_no, oe_no, we_no, adv_no;
    fmc_init_state_t dbg_state;

    fmc_initiator dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_write_i  (cmd_write),
        .cmd_addr_i   (cmd_addr),
        .cmd_len_i    (cmd_len),
        .wdata_valid_i(wdata_valid),
        .wdata_ready_o(wdata_ready),
        .wdata_i      (wdata),
        .rdata_valid_o(rdata_valid),
        .rdata_o      (rdata),
        .rdata_last_o (rdata_last),
        .data_io      (bus),
        .cs_no        (cs_no),
        .oe_no        (oe_no),
        .we_no        (we_no),
        .adv_no       (adv_no),
        .dbg_state_o  (dbg_state)
    );

    // behavioural responder: 256-word memory, auto-incrementing pointer
    logic [15:0] r_mem [256];
    logic [7:0]  r_ptr = '0;
    logic        r_init = 1'b0;
    wire         r_drive = !cs_no && !oe_no;
    assign bus = r_drive ? r_mem[r_ptr] : 16'hzzzz;

    function automatic logic [15:0] init_word(input int i);
        return 16'(i * 40503) ^ 16'h5A5A;
    endfunction

    always @(posedge clk) begin
        if (!r_init) begin
            for (int i = 0; i < 256; i++) r_mem[i] <= init_word(i);
            r_init <= 1'b1;
        end else if (!cs_no && !adv_no) begin
            r_ptr <= bus[7:0];
        end else if (!cs_no && !we_no) begin
            r_mem[r_ptr] <= bus;
            r_ptr        <= r_ptr + 8'd1;
        end else if (!cs_no && !oe_no) begin
            r_ptr <= r_ptr + 8'd1;
        end
    end

    // reference memory and scoreboard
    logic [15:0] ref_mem [256];
    exp_t        exp_q[$];
    logic [16:0] got_rd[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          adv_cnt, we_cnt, lat_cnt;
    logic [15:0] adv_bus, we_bus;
    exp_t        cmp_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, want);
        end
    endtask

    // compare process
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cmp_e = exp_q.pop_front();
            chk("cs_no", 32'(cs_no), 32'(cmp_e.cs));
            chk("adv_no", 32'(adv_no), 32'(cmp_e.adv));
            chk("oe_no", 32'(oe_no), 32'(cmp_e.oe));
            chk("we_no", 32'(we_no), 32'(cmp_e.we));
            chk("cmd_ready", 32'(cmd_ready), 32'(cmp_e.crdy));
            chk("wdata_ready", 32'(wdata_ready), 32'(cmp_e.wrdy));
            chk("rdata_valid", 32'(rdata_valid), 32'(cmp_e.rval));
            chk("rdata_last", 32'(rdata_last), 32'(cmp_e.rlast));
            if (cmp_e.drv) chk("bus_drive", 32'(bus), 32'(cmp_e.bus));
            if (cmp_e.rval || cmp_e.chk_rd) chk("rdata", 32'(rdata), 32'(cmp_e.rdata));
            if (rdata_valid) got_rd.push_back({rdata_last, rdata});
            if (!adv_no) begin adv_cnt++; adv_bus = bus; end
            if (!we_no) begin we_cnt++; we_bus = bus; end
            if (!cs_no && adv_no && oe_no && we_no) lat_cnt++;
        end
    end

    // expected-record helpers
    function automatic exp_t idle_e();
        exp_t e;
        e = '0;
        e.cs = 1'b1; e.adv = 1'b1; e.oe = 1'b1; e.we = 1'b1; e.crdy = 1'b1;
        return e;
    endfunction

    function automatic exp_t busy_e();
        exp_t e;
        e = '0;
        e.cs = 1'b0; e.adv = 1'b1; e.oe = 1'b1; e.we = 1'b1; e.crdy = 1'b0;
        return e;
    endfunction

    // driver tasks
    task automatic step(input exp_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic busy_inputs();
        cmd_valid   = 1'($urandom_range(0, 1));
        cmd_write   = 1'($urandom_range(0, 1));
        cmd_addr    = 16'($urandom);
        cmd_len     = 8'($urandom);
        wdata_valid = 1'($urandom_range(0, 1));
        wdata       = 16'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cmd_valid   = 1'b0;
            wdata_valid = 1'($urandom_range(0, 1));
            wdata       = 16'($urandom);
            step(idle_e());
        end
    endtask

    task automatic do_cmd(input bit wr, input logic [15:0] addr, input logic [7:0] len,
                          input bit seq, input logic [15:0] base,
                          input int gap_after, input int gap_len, input bit rnd_gaps,
                          input int rst_beat);
        exp_t        e;
        logic [15:0] rd_exp[$];
        logic [15:0] w;
        int          beats, gap_left;
        bit          v;
        // acceptance cycle in IDLE
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
        wdata_valid = 1'($urandom_range(0, 1)); wdata = 16'($urandom);
        step(idle_e());
        // address cycle
        busy_inputs();
        e = busy_e(); e.adv = 1'b0; e.drv = 1'b1; e.bus = addr;
        step(e);
        // latency gap
        for (int i = 0; i < L; i++) begin
            busy_inputs();
            step(busy_e());
        end
        if (wr) begin
            beats = 0;
            gap_left = gap_len;
            while (beats <= int'(len)) begin
                busy_inputs();
                if (beats == gap_after && gap_left > 0) begin
                    v = 1'b0;
                    gap_left--;
                end else if (rnd_gaps) begin
                    v = ($urandom_range(0, 3) != 0);
                end else begin
                    v = 1'b1;
                end
                w = seq ? 16'(base + 16'(beats)) : 16'($urandom);
                wdata_valid = v;
                wdata = w;
                e = busy_e(); e.wrdy = 1'b1; e.we = !v; e.drv = v; e.bus = w;
                if (v) begin
                    ref_mem[8'(addr[7:0] + 8'(beats))] = w;
                    beats++;
                end
                step(e);
            end
        end else begin
            for (int k = 0; k <= int'(len); k++) rd_exp.push_back(ref_mem[8'(addr[7:0] + 8'(k))]);
            for (int k = 0; k <= int'(len); k++) begin
                if (k == rst_beat) begin
                    cmd_valid = 1'b0;
                    wdata_valid = 1'b0;
                    rst_ni = 1'b0;
                    e = idle_e(); e.chk_rd = 1'b1; e.rdata = 16'h0000;
                    step(e);
                    rst_ni = 1'b1;
                    step(e);
                    idle(3);
                    return;
                end
                busy_inputs();
                e = busy_e(); e.oe = 1'b0;
                if (k > 0) begin e.rval = 1'b1; e.rdata = rd_exp[k-1]; end
                step(e);
            end
        end
        // recovery cycle
        busy_inputs();
        e = busy_e(); e.cs = 1'b1;
        if (!wr) begin e.rval = 1'b1; e.rlast = 1'b1; e.rdata = rd_exp[len]; end
        step(e);
    endtask

    task automatic clear_log();
        got_rd.delete();
        adv_cnt = 0; we_cnt = 0; lat_cnt = 0;
        adv_bus = '0; we_bus = '0;
    endtask

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // main sequence
    initial begin
        exp_t e;
        logic [15:0] lit_a [4];
        lit_a[0] = 16'hA000; lit_a[1] = 16'hA001; lit_a[2] = 16'hA002; lit_a[3] = 16'hA003;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        clear_log();

        // reset state
        @(posedge clk);
        #1;
        e = idle_e(); e.chk_rd = 1'b1; e.rdata = 16'h0000;
        for (int i = 0; i < 3; i++) step(e);
        rst_ni = 1'b1;
        idle(2);

        // write burst then readback
        do_cmd(1'b1, 16'h0010, 8'd3, 1'b1, 16'hA000, -1, 0, 1'b0, -1);
        idle(2);
        clear_log();
        do_cmd(1'b0, 16'h0010, 8'd3, 1'b0, 16'h0, -1, 0, 1'b0, -1);
        idle(2);
        chk("s1_beats", 32'(got_rd.size()), 32'd4);
        for (int i = 0; i < 4 && i < got_rd.size(); i++) begin
            chk("s1_word", 32'(got_rd[i][15:0]), 32'(lit_a[i]));
            chk("s1_last", 32'(got_rd[i][16]), (i == 3) ? 32'd1 : 32'd0);
        end

        // strobe check: single write
        clear_log();
        do_cmd(1'b1, 16'h0042, 8'd0, 1'b1, 16'hBEEF, -1, 0, 1'b0, -1);
        idle(2);
        chk("s2_adv_cycles", 32'(adv_cnt), 32'd1);
        chk("s2_adv_bus", 32'(adv_bus), 32'h0042);
        chk("s2_lat_cycles", 32'(lat_cnt), 32'd2);
        chk("s2_we_cycles", 32'(we_cnt), 32'd1);
        chk("s2_we_bus", 32'(we_bus), 32'hBEEF);

        // write stall of 3 cycles after the second word, then readback
        for (int i = 0; i < 4; i++) ref_mem[8'h10 + i] = 16'h0;
        do_cmd(1'b1, 16'h0010, 8'd3, 1'b1, 16'hA000, 2, 3, 1'b0, -1);
        idle(1);
        clear_log();
        do_cmd(1'b0, 16'h0010, 8'd3, 1'b0, 16'h0, -1, 0, 1'b0, -1);
        idle(2);
        chk("s3_beats", 32'(got_rd.size()), 32'd4);
        for (int i = 0; i < 4 && i < got_rd.size(); i++)
            chk("s3_word", 32'(got_rd[i][15:0]), 32'(lit_a[i]));

        // back-to-back reads with cmd_valid kept high
        do_cmd(1'b0, 16'h0010, 8'd1, 1'b0, 16'h0, -1, 0, 1'b0, -1);
        do_cmd(1'b0, 16'h0020, 8'd2, 1'b0, 16'h0, -1, 0, 1'b0, -1);
        idle(2);

        // reset during the third read beat
        clear_log();
        do_cmd(1'b0, 16'h0010, 8'd7, 1'b0, 16'h0, -1, 0, 1'b0, 2);
        chk("s5_beats", 32'(got_rd.size()), 32'd1);
        if (got_rd.size() > 0) chk("s5_word", 32'(got_rd[0][15:0]), 32'hA000);

        // maximum burst crossing the responder's wrap point
        do_cmd(1'b1, 16'h00FF, 8'd255, 1'b1, 16'h1000, -1, 0, 1'b1, -1);
        idle(1);
        clear_log();
        do_cmd(1'b0, 16'h00FF, 8'd255, 1'b0, 16'h0, -1, 0, 1'b0, -1);
        idle(2);
        chk("s6_beats", 32'(got_rd.size()), 32'd256);
        chk("s6_adv_cycles", 32'(adv_cnt), 32'd1);
        if (got_rd.size() == 256) begin
            chk("s6_first", 32'(got_rd[0][15:0]), 32'h1000);
            chk("s6_wrap", 32'(got_rd[1][15:0]), 32'h1001);
            chk("s6_final", 32'(got_rd[255][15:0]), 32'h10FF);
            chk("s6_last_flag", 32'(got_rd[255][16]), 32'd1);
            chk("s6_not_last", 32'(got_rd[254][16]), 32'd0);
        end

        // randomized traffic
        for (int n = 0; n < 24; n++) begin
            do_cmd(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom_range(0, 15)),
                   1'b0, 16'h0, -1, 0, 1'b1, -1);
            idle($urandom_range(0, 2));
        end

        idle(2);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_fmc_initiator
